// File: rtl/packet_interconnect.sv
// packet_interconnect: N-to-1 packet merge with one-entry register slices
// on every input lane and on the output, joined by a combinational arbiter.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   IN_VALID   per-lane packet valid             [CONNECT_NUM]
//   IN_READY   per-lane ready                    [CONNECT_NUM]
//   IN_DATA    flattened lanes, lane i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
//   OUT_VALID  output packet valid
//   OUT_READY  consumer ready
//   OUT_DATA   output packet                     [DATA_WIDTH]
//
// Build option: INTERCONNECT_ROUND_ROBIN_EN selects a round-robin grant
// pointer; left undefined, the highest-index full lane always wins.

module packet_interconnect #(
   parameter int DATA_WIDTH  = 192,
   parameter int CONNECT_NUM = 3
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [CONNECT_NUM-1:0]            IN_VALID,
   output logic [CONNECT_NUM-1:0]            IN_READY,
   input  logic [DATA_WIDTH*CONNECT_NUM-1:0] IN_DATA,
   output logic                              OUT_VALID,
   input  logic                              OUT_READY,
   output logic [DATA_WIDTH-1:0]             OUT_DATA
);

   localparam int IW = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;

   logic [CONNECT_NUM-1:0]                 in_full;
   logic [CONNECT_NUM-1:0][DATA_WIDTH-1:0] in_data;
   logic [CONNECT_NUM-1:0]                 in_dn_ready;

   logic                  out_full;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_up_ready;

   logic [IW-1:0]         gnt_idx;
   logic                  arb_valid;
   logic [DATA_WIDTH-1:0] arb_data;

   assign out_up_ready = ~out_full | OUT_READY;
   assign arb_valid    = |in_full;
   assign arb_data     = in_data[gnt_idx];

`ifdef INTERCONNECT_ROUND_ROBIN_EN
   logic [IW-1:0] rr_ptr;

   // Search starts at the lane after the last winner and wraps around.
   always_comb begin
      int   idx;
      logic found;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < CONNECT_NUM; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= CONNECT_NUM)
            idx = idx - CONNECT_NUM;
         if (!found && in_full[idx]) begin
            gnt_idx = IW'(idx);
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         rr_ptr <= '0;
      else if (arb_valid && out_up_ready)
         rr_ptr <= (gnt_idx == IW'(CONNECT_NUM - 1)) ? '0 : gnt_idx + IW'(1);
   end
`else
   // Later (higher) indices overwrite earlier ones: highest full lane wins.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < CONNECT_NUM; i++)
         if (in_full[i])
            gnt_idx = IW'(i);
   end
`endif

   // Only the granted slice sees the output slice's ready; others hold.
   always_comb begin
      in_dn_ready = '0;
      for (int i = 0; i < CONNECT_NUM; i++)
         in_dn_ready[i] = in_full[i] & out_up_ready & (gnt_idx == IW'(i));
   end

   assign IN_READY = ~in_full | in_dn_ready;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         in_full <= '0;
         in_data <= '0;
      end else begin
         for (int i = 0; i < CONNECT_NUM; i++) begin
            if (IN_VALID[i] && IN_READY[i]) begin
               in_data[i] <= IN_DATA[DATA_WIDTH*i +: DATA_WIDTH];
               in_full[i] <= 1'b1;
            end else if (in_dn_ready[i]) begin
               in_full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_full <= 1'b0;
         out_data <= '0;
      end else if (arb_valid && out_up_ready) begin
         out_data <= arb_data;
         out_full <= 1'b1;
      end else if (out_full && OUT_READY) begin
         out_full <= 1'b0;
      end
   end

   assign OUT_VALID = out_full;
   assign OUT_DATA  = out_data;

endmodule

// File: tb/tb_packet_interconnect.sv
// tb_packet_interconnect: scoreboard bench for packet_interconnect.
// Expected packets are queued in arbitration order and popped on output.

module tb_packet_interconnect;

   localparam int DW = 192;
   localparam int N  = 3;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic [N-1:0]    IN_VALID = '0;
   logic [N-1:0]    IN_READY;
   logic [DW*N-1:0] IN_DATA = '0;
   logic            OUT_VALID;
   logic            OUT_READY = 1'b0;
   logic [DW-1:0]   OUT_DATA;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sb[$];
   bit rand_rdy = 1'b0;

   packet_interconnect #(
      .DATA_WIDTH (DW),
      .CONNECT_NUM(N)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .IN_DATA  (IN_DATA),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .OUT_DATA (OUT_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Output monitor: a transfer happens on the next edge.
   always @(negedge CLK) begin
      if (RST && OUT_VALID && OUT_READY) begin
         chk("sb_pending", DW'(sb.size() != 0), DW'(1));
         if (sb.size() != 0)
            chk("out_data", OUT_DATA, sb.pop_front());
      end
   end

   always @(posedge CLK) begin
      if (rand_rdy) begin
         #1;
         OUT_READY = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input int l, input logic [DW-1:0] d);
      IN_DATA[l*DW +: DW] = d;
      IN_VALID[l] = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge CLK);
         if (IN_READY[l]) begin
            @(posedge CLK);
            #1;
            IN_VALID[l] = 1'b0;
            return;
         end
      end
      chk("send_timeout", DW'(IN_READY[l]), DW'(1));
      IN_VALID[l] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && (sb.size() != 0 || OUT_VALID); t++) begin
         @(posedge CLK);
         #1;
      end
      chk("drain", DW'(sb.size()), DW'(0));
   endtask

   task automatic sc_three(input bit stagger);
      logic [DW-1:0] d0, d1, d2;
      d0 = rnd(); d1 = rnd(); d2 = rnd();
      sb.push_back(d2);
      sb.push_back(d1);
      sb.push_back(d0);
      if (!stagger) begin
         fork
            send(0, d0);
            send(1, d1);
            send(2, d2);
         join
      end else begin
         send(2, d2);
         send(1, d1);
         send(0, d0);
      end
      drain();
   endtask

   task automatic sc_two();
      logic [DW-1:0] d0, d1;
      d0 = rnd(); d1 = rnd();
      sb.push_back(d1);
      sb.push_back(d0);
      fork
         send(0, d0);
         send(1, d1);
      join
      drain();
   endtask

   task automatic sc_backpressure();
      logic [DW-1:0] a0, a1, a2, b0, b1, b2;
      a0 = rnd(); a1 = rnd(); a2 = rnd();
      b0 = rnd(); b1 = rnd(); b2 = rnd();
      OUT_READY = 1'b0;
      sb.push_back(a2); sb.push_back(b2);
      sb.push_back(a1); sb.push_back(b1);
      sb.push_back(a0); sb.push_back(b0);
      fork
         begin send(0, a0); send(0, b0); end
         begin send(1, a1); send(1, b1); end
         begin send(2, a2); send(2, b2); end
         begin
            repeat (10) @(posedge CLK);
            #1;
            chk("bp_in_ready", DW'(IN_READY), DW'(0));
            chk("bp_out_valid", DW'(OUT_VALID), DW'(1));
            OUT_READY = 1'b1;
         end
      join
      drain();
   endtask

   initial begin
      logic [DW-1:0] a, x;

      // Reset
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_out_valid", DW'(OUT_VALID), DW'(0));
      chk("rst_out_data", OUT_DATA, DW'(0));
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst_in_ready", DW'(IN_READY), DW'(3'b111));

      // Single lane latency
      OUT_READY = 1'b1;
      a = rnd();
      sb.push_back(a);
      IN_DATA[DW +: DW] = a;
      IN_VALID[1] = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID[1] = 1'b0;
      @(negedge CLK);
      chk("lat_e0_valid", DW'(OUT_VALID), DW'(0));
      @(negedge CLK);
      chk("lat_e1_valid", DW'(OUT_VALID), DW'(1));
      chk("lat_e1_data", OUT_DATA, a);
      @(negedge CLK);
      chk("lat_e2_valid", DW'(OUT_VALID), DW'(0));
      @(posedge CLK);
      #1;
      drain();

      // Contention and backpressure
      sc_three(1'b0);
      sc_three(1'b1);
      sc_two();
      sc_backpressure();

      // Reset with packets buffered discards them
      OUT_READY = 1'b0;
      x = rnd();
      send(0, x);
      send(2, rnd());
      repeat (2) @(posedge CLK);
      #1;
      chk("mid_full", DW'(OUT_VALID), DW'(1));
      RST = 1'b0;
      #1;
      chk("mid_rst_valid", DW'(OUT_VALID), DW'(0));
      chk("mid_rst_data", OUT_DATA, DW'(0));
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("mid_rst_ready", DW'(IN_READY), DW'(3'b111));
      OUT_READY = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      chk("mid_rst_empty", DW'(OUT_VALID), DW'(0));

      // Stress with a random consumer
      rand_rdy = 1'b1;
      for (int it = 0; it < 100; it++) begin
         sc_three(1'b0);
         sc_three(1'b1);
         sc_two();
      end
      rand_rdy = 1'b0;
      @(posedge CLK);
      #2;
      OUT_READY = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
